// File: rtl/mux_sel_reg_if.sv
// Bus between the mux_sel_reg and its sources/consumer: packed channel
// sources, single-capture request port, scan control and the captured output.
interface mux_sel_reg_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
);
    logic [CHANNELS*WIDTH-1:0] din;
    logic [SEL_W-1:0]          sel;
    logic                      req;
    logic                      req_ready;
    logic                      scan;
    logic [WIDTH-1:0]          y;
    logic [SEL_W-1:0]          y_ch;
    logic                      y_err;
    logic                      y_valid;
    logic                      y_ready;
    logic                      scan_busy;
    logic                      scan_done;

    // Handshake: a request transfers on a rising edge where req & req_ready;
    // an output word transfers where y_valid & y_ready. Once raised, y_valid
    // and y/y_ch/y_err stay stable until the word is taken.
    modport master (
        output din, sel, req, scan, y_ready,
        input  req_ready, y, y_ch, y_err, y_valid, scan_busy, scan_done
    );

    modport slave (
        input  din, sel, req, scan, y_ready,
        output req_ready, y, y_ch, y_err, y_valid, scan_busy, scan_done
    );
endinterface

// File: rtl/mux_sel_reg.sv
// Registered CHANNELS:1 mux with a one-deep output register, valid/ready
// handshake, and a scan mode that captures every channel once, in order.
module mux_sel_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic         clk,
    input  logic         reset,
    mux_sel_reg_if.slave bus,
    output logic         o_dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_scan_idx;
    logic [WIDTH-1:0] r_y;
    logic [SEL_W-1:0] r_y_ch;
    logic             r_y_err;
    logic             r_y_valid;
    logic             r_scan_done;

    logic             w_slot_free;
    logic             w_req_fire;
    logic             w_sel_in_range;
    logic             w_scan_last;
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] w_scan_data;

    // Out-of-range selects match no channel and therefore read as zero.
    always_comb begin
        w_sel_data  = '0;
        w_scan_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.sel == SEL_W'(k))
                w_sel_data = bus.din[k*WIDTH +: WIDTH];
            if (r_scan_idx == SEL_W'(k))
                w_scan_data = bus.din[k*WIDTH +: WIDTH];
        end
    end

    assign w_slot_free    = !r_y_valid || bus.y_ready;
    assign w_sel_in_range = 32'(bus.sel) < 32'(CHANNELS);
    assign w_scan_last    = (r_scan_idx == SEL_W'(CHANNELS - 1));
    assign w_req_fire     = bus.req && bus.req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_scan_idx  <= '0;
            r_y         <= '0;
            r_y_ch      <= '0;
            r_y_err     <= 1'b0;
            r_y_valid   <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            // A consume clears valid; a load in the same cycle overrides it.
            if (r_y_valid && bus.y_ready)
                r_y_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.scan) begin
                        r_state    <= ST_SCAN;
                        r_scan_idx <= '0;
                    end else if (w_req_fire) begin
                        r_y       <= w_sel_data;
                        r_y_ch    <= bus.sel;
                        r_y_err   <= !w_sel_in_range;
                        r_y_valid <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_slot_free) begin
                        r_y       <= w_scan_data;
                        r_y_ch    <= r_scan_idx;
                        r_y_err   <= 1'b0;
                        r_y_valid <= 1'b1;
                        if (w_scan_last) begin
                            r_state     <= ST_IDLE;
                            r_scan_done <= 1'b1;
                        end else begin
                            r_scan_idx <= r_scan_idx + SEL_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE) && w_slot_free && !bus.scan;
    assign bus.y         = r_y;
    assign bus.y_ch      = r_y_ch;
    assign bus.y_err     = r_y_err;
    assign bus.y_valid   = r_y_valid;
    assign bus.scan_busy = (r_state == ST_SCAN);
    assign bus.scan_done = r_scan_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mux_sel_reg.sv
// Directed bench for mux_sel_reg: an 8-channel instance for request, backpressure,
// scan and reset cases, a 6-channel instance for out-of-range selects and scan/req priority.
module tb_mux_sel_reg;

    logic clk = 1'b0;
    logic reset;
    logic dbg_a;
    logic dbg_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mux_sel_reg_if #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) ifa ();
    mux_sel_reg_if #(.WIDTH(8), .CHANNELS(6), .SEL_W(3)) ifb ();

    mux_sel_reg #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .bus         (ifa),
        .o_dbg_state (dbg_a)
    );

    mux_sel_reg #(.WIDTH(8), .CHANNELS(6), .SEL_W(3)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .bus         (ifb),
        .o_dbg_state (dbg_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic [7:0] ey, input logic [2:0] ech,
                            input logic eerr, input logic ev);
        check({tag, "_y"}, 32'(ifa.y), 32'(ey));
        check({tag, "_ch"}, 32'(ifa.y_ch), 32'(ech));
        check({tag, "_err"}, 32'(ifa.y_err), 32'(eerr));
        check({tag, "_valid"}, 32'(ifa.y_valid), 32'(ev));
    endtask

    task automatic expect_b(input string tag, input logic [7:0] ey, input logic [2:0] ech,
                            input logic eerr, input logic ev);
        check({tag, "_y"}, 32'(ifb.y), 32'(ey));
        check({tag, "_ch"}, 32'(ifb.y_ch), 32'(ech));
        check({tag, "_err"}, 32'(ifb.y_err), 32'(eerr));
        check({tag, "_valid"}, 32'(ifb.y_valid), 32'(ev));
    endtask

    task automatic expect_reset_a(input string tag);
        expect_a(tag, 8'h00, 3'd0, 1'b0, 1'b0);
        check({tag, "_done"}, 32'(ifa.scan_done), 0);
        check({tag, "_busy"}, 32'(ifa.scan_busy), 0);
        check({tag, "_state"}, 32'(dbg_a), 0);
        check({tag, "_rr"}, 32'(ifa.req_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        int extra_cnt;
        logic [7:0] exp_w;
        logic found;

        reset = 1'b1;
        ifa.din = '0; ifa.sel = '0; ifa.req = 1'b0; ifa.scan = 1'b0; ifa.y_ready = 1'b1;
        ifb.din = '0; ifb.sel = '0; ifb.req = 1'b0; ifb.scan = 1'b0; ifb.y_ready = 1'b1;
        for (int k = 0; k < 8; k++) ifa.din[k*8 +: 8] = 8'(16 + k);
        for (int k = 0; k < 6; k++) ifb.din[k*8 +: 8] = 8'(32 + k);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        expect_reset_a("rst");

        // Single request, consumed immediately
        @(negedge clk); ifa.sel = 3'd5; ifa.req = 1'b1; #1;
        check("t1_rr", 32'(ifa.req_ready), 1);
        @(negedge clk); ifa.req = 1'b0; #1;
        expect_a("t1", 8'h15, 3'd5, 1'b0, 1'b1);
        @(negedge clk); #1;
        check("t1_drain_valid", 32'(ifa.y_valid), 0);
        check("t1_drain_y", 32'(ifa.y), 32'h15);

        // Backpressure
        @(negedge clk); ifa.y_ready = 1'b0; ifa.sel = 3'd2; ifa.req = 1'b1; #1;
        check("bp_rr0", 32'(ifa.req_ready), 1);
        @(negedge clk); ifa.sel = 3'd3; #1;
        expect_a("bp1", 8'h12, 3'd2, 1'b0, 1'b1);
        check("bp1_rr", 32'(ifa.req_ready), 0);
        @(negedge clk); #1;
        expect_a("bp2", 8'h12, 3'd2, 1'b0, 1'b1);
        check("bp2_rr", 32'(ifa.req_ready), 0);
        @(negedge clk); ifa.y_ready = 1'b1; #1;
        check("bp3_rr", 32'(ifa.req_ready), 1);
        check("bp3_hold_y", 32'(ifa.y), 32'h12);
        @(negedge clk); ifa.req = 1'b0; #1;
        expect_a("bp4", 8'h13, 3'd3, 1'b0, 1'b1);
        @(negedge clk); #1;
        check("bp5_valid", 32'(ifa.y_valid), 0);

        // Full-rate scan
        @(negedge clk); ifa.scan = 1'b1; #1;
        check("scan_start_rr", 32'(ifa.req_ready), 0);
        @(negedge clk); ifa.scan = 1'b0; #1;
        check("scan_busy", 32'(ifa.scan_busy), 1);
        check("scan_pre_valid", 32'(ifa.y_valid), 0);
        check("scan_pre_rr", 32'(ifa.req_ready), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            expect_a($sformatf("scan%0d", i), 8'(16 + i), 3'(i), 1'b0, 1'b1);
            check($sformatf("scan%0d_done", i), 32'(ifa.scan_done), 32'(i == 7));
            check($sformatf("scan%0d_busy", i), 32'(ifa.scan_busy), 32'(i != 7));
            check($sformatf("scan%0d_rr", i), 32'(ifa.req_ready), 32'(i == 7));
        end
        @(negedge clk); #1;
        check("scan_end_done", 32'(ifa.scan_done), 0);
        check("scan_end_valid", 32'(ifa.y_valid), 0);

        // Scan under toggling y_ready, words checked through the expected queue
        exp_q = {};
        for (int k = 0; k < 8; k++) exp_q.push_back(8'(16 + k));
        done_cnt = 0;
        extra_cnt = 0;
        @(negedge clk); ifa.scan = 1'b1; ifa.y_ready = 1'b1;
        @(negedge clk); ifa.scan = 1'b0;
        for (int c = 0; c < 40 && (exp_q.size() != 0 || ifa.scan_busy); c++) begin
            @(negedge clk);
            ifa.y_ready = ~c[0];
            #1;
            if (ifa.scan_done) begin
                done_cnt++;
                check("tg_done_ch", 32'(ifa.y_ch), 7);
                check("tg_done_valid", 32'(ifa.y_valid), 1);
            end
            if (ifa.y_valid && ifa.y_ready) begin
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check("tg_word", 32'(ifa.y), 32'(exp_w));
                    check("tg_ch", 32'(ifa.y_ch), 32'(exp_w - 8'h10));
                end else begin
                    extra_cnt++;
                end
            end
        end
        check("tg_left", exp_q.size(), 0);
        check("tg_extra", extra_cnt, 0);
        check("tg_done_cnt", done_cnt, 1);
        ifa.y_ready = 1'b1;
        @(negedge clk);

        // Reset in the middle of a scan
        @(negedge clk); ifa.scan = 1'b1;
        @(negedge clk); ifa.scan = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (ifa.y_valid && ifa.y_ch == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        check("mr_reach_ch3", 32'(found), 1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        expect_reset_a("mr");
        ifa.sel = 3'd1; ifa.req = 1'b1;
        @(negedge clk); ifa.req = 1'b0; #1;
        expect_a("mr_req", 8'h11, 3'd1, 1'b0, 1'b1);
        @(negedge clk); #1;
        check("mr_after_valid", 32'(ifa.y_valid), 0);
        check("mr_after_busy", 32'(ifa.scan_busy), 0);

        // Six-channel instance: out-of-range selects and last valid channel
        @(negedge clk); ifb.sel = 3'd7; ifb.req = 1'b1; ifb.y_ready = 1'b1; #1;
        check("b_rr", 32'(ifb.req_ready), 1);
        @(negedge clk); ifb.sel = 3'd5; #1;
        expect_b("b_sel7", 8'h00, 3'd7, 1'b1, 1'b1);
        check("b_rr2", 32'(ifb.req_ready), 1);
        @(negedge clk); ifb.sel = 3'd6; #1;
        expect_b("b_sel5", 8'h25, 3'd5, 1'b0, 1'b1);
        @(negedge clk); ifb.req = 1'b0; #1;
        expect_b("b_sel6", 8'h00, 3'd6, 1'b1, 1'b1);

        // Scan and request together in IDLE: scan wins
        @(negedge clk); ifb.scan = 1'b1; ifb.req = 1'b1; ifb.sel = 3'd2; #1;
        check("b_sr_rr", 32'(ifb.req_ready), 0);
        @(negedge clk); ifb.scan = 1'b0; ifb.req = 1'b0; #1;
        check("b_sr_busy", 32'(ifb.scan_busy), 1);
        check("b_sr_valid", 32'(ifb.y_valid), 0);
        check("b_sr_ch", 32'(ifb.y_ch), 6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            expect_b($sformatf("b_scan%0d", i), 8'(32 + i), 3'(i), 1'b0, 1'b1);
            check($sformatf("b_scan%0d_done", i), 32'(ifb.scan_done), 32'(i == 5));
        end
        @(negedge clk); #1;
        check("b_end_busy", 32'(ifb.scan_busy), 0);
        check("b_end_done", 32'(ifb.scan_done), 0);
        check("b_end_valid", 32'(ifb.y_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
